// File: rtl/scsi_initiator.sv
// SCSI initiator: selects a target, walks the bus phases it drives, moves CDB/data/status/message bytes.
// Latency: ack rises one cycle after req is sampled (data-out: after tx_valid too); done one cycle after bus free.
// Backpressure: data-out waits on tx_valid (tx_ready marks the consuming cycle); data-in has no stall, rx_valid pulses.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start, target_id, cmd_len     transaction request (accepted only when idle and bsy low)
//   cmd_wr, cmd_addr, cmd_wdata   10-entry CDB buffer write port (ignored while busy)
//   busy, done, error, status     transaction status; error is sticky until the next accepted start
//   rx_data, rx_valid             data-in byte stream
//   tx_data, tx_valid, tx_ready   data-out byte stream, byte taken when tx_valid && tx_ready
//   byte_cnt                      data bytes moved this transaction (wraps)
//   scsi_rst, sel, atn, ack, dout initiator-driven SCSI signals
//   bsy, msg, cd, io, req, din    target-driven SCSI signals
//
// Build option: define SCSI_INIT_SEL_TIMEOUT_EN to abandon selection after SEL_TIMEOUT cycles
// without bsy; otherwise selection waits indefinitely.
module scsi_initiator #(
    parameter int ID          = 7,
    parameter int SEL_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  target_id,
    input  logic [3:0]  cmd_len,
    input  logic        cmd_wr,
    input  logic [3:0]  cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  status,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [31:0] byte_cnt,
    output logic        scsi_rst,
    output logic        sel,
    output logic        atn,
    output logic        ack,
    input  logic        bsy,
    input  logic        msg,
    input  logic        cd,
    input  logic        io,
    input  logic        req,
    output logic [7:0]  dout,
    input  logic [7:0]  din
);

    localparam logic [7:0] OWN_BIT = 8'(1 << ID);

    // Bus phase encoding {msg, cd, io}
    localparam logic [2:0] PH_DOUT = 3'b000;
    localparam logic [2:0] PH_DIN  = 3'b001;
    localparam logic [2:0] PH_CMD  = 3'b010;
    localparam logic [2:0] PH_STAT = 3'b011;
    localparam logic [2:0] PH_MSGI = 3'b111;

    if (SEL_TIMEOUT < 1) begin : g_bad_sel_timeout
        $error("scsi_initiator: SEL_TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_XFER_WAIT,
        S_XFER_ACK,
        S_BUS_FREE,
        S_DONE
    } state_t;

    state_t      state;
    logic [7:0]  cdb [0:9];
    logic [3:0]  cmd_idx;
    logic [3:0]  len_q;
    logic [7:0]  msg_byte;
    logic        msg_rcvd;
    logic [2:0]  phase;

`ifdef SCSI_INIT_SEL_TIMEOUT_EN
    logic [31:0] sel_cnt;
`endif

    assign phase    = {msg, cd, io};
    assign atn      = 1'b0;
    assign scsi_rst = 1'b0;

    // tx_ready must coincide with the cycle the byte is actually taken, so it is
    // decoded from the current state and bus lines rather than registered.
    assign tx_ready = (state == S_XFER_WAIT) && bsy && req && (phase == PH_DOUT);

    // CDB buffer has no reset; it is frozen for the whole transaction.
    always_ff @(posedge clk) begin
        if (cmd_wr && !busy && (cmd_addr < 4'd10)) begin
            cdb[cmd_addr] <= cmd_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            status   <= 8'h00;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            byte_cnt <= 32'd0;
            sel      <= 1'b0;
            ack      <= 1'b0;
            dout     <= 8'h00;
            cmd_idx  <= 4'd0;
            len_q    <= 4'd0;
            msg_byte <= 8'h00;
            msg_rcvd <= 1'b0;
`ifdef SCSI_INIT_SEL_TIMEOUT_EN
            sel_cnt  <= 32'd0;
`endif
        end else begin
            rx_valid <= 1'b0;
            done     <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start && !bsy) begin
                        state    <= S_SELECT;
                        busy     <= 1'b1;
                        error    <= 1'b0;
                        byte_cnt <= 32'd0;
                        cmd_idx  <= 4'd0;
                        len_q    <= cmd_len;
                        msg_byte <= 8'h00;
                        msg_rcvd <= 1'b0;
                        sel      <= 1'b1;
                        dout     <= OWN_BIT | (8'd1 << target_id);
`ifdef SCSI_INIT_SEL_TIMEOUT_EN
                        sel_cnt  <= 32'd0;
`endif
                    end
                end

                S_SELECT: begin
                    if (bsy) begin
                        sel   <= 1'b0;
                        state <= S_XFER_WAIT;
                    end
`ifdef SCSI_INIT_SEL_TIMEOUT_EN
                    else if (sel_cnt == 32'(SEL_TIMEOUT - 1)) begin
                        sel   <= 1'b0;
                        dout  <= 8'h00;
                        error <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        sel_cnt <= sel_cnt + 32'd1;
                    end
`endif
                end

                S_XFER_WAIT: begin
                    // A message byte always leads to BUS_FREE, so bsy low here is
                    // always an unexpected bus free.
                    if (!bsy) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (req) begin
                        case (phase)
                            PH_CMD: begin
                                if ((cmd_idx < len_q) && (cmd_idx < 4'd10)) begin
                                    dout <= cdb[cmd_idx];
                                end else begin
                                    // Target asked for more CDB than we have
                                    dout  <= 8'h00;
                                    error <= 1'b1;
                                end
                                if (cmd_idx != 4'hF) begin
                                    cmd_idx <= cmd_idx + 4'd1;
                                end
                                ack   <= 1'b1;
                                state <= S_XFER_ACK;
                            end
                            PH_DIN: begin
                                rx_data  <= din;
                                rx_valid <= 1'b1;
                                byte_cnt <= byte_cnt + 32'd1;
                                ack      <= 1'b1;
                                state    <= S_XFER_ACK;
                            end
                            PH_DOUT: begin
                                if (tx_valid) begin
                                    dout     <= tx_data;
                                    byte_cnt <= byte_cnt + 32'd1;
                                    ack      <= 1'b1;
                                    state    <= S_XFER_ACK;
                                end
                            end
                            PH_STAT: begin
                                status <= din;
                                ack    <= 1'b1;
                                state  <= S_XFER_ACK;
                            end
                            PH_MSGI: begin
                                msg_byte <= din;
                                msg_rcvd <= 1'b1;
                                ack      <= 1'b1;
                                state    <= S_XFER_ACK;
                            end
                            default: begin
                                // Unsupported phase: flag it but still complete the
                                // handshake so the target is not left hanging.
                                error <= 1'b1;
                                dout  <= 8'h00;
                                ack   <= 1'b1;
                                state <= S_XFER_ACK;
                            end
                        endcase
                    end
                end

                S_XFER_ACK: begin
                    if (!req) begin
                        ack <= 1'b0;
                        if (msg_rcvd) begin
                            if (msg_byte != 8'h00) begin
                                error <= 1'b1;
                            end
                            state <= S_BUS_FREE;
                        end else begin
                            state <= S_XFER_WAIT;
                        end
                    end
                end

                S_BUS_FREE: begin
                    if (!bsy) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
